gcd_div_coproc: RTL and testbench

//  Iterative subtract-based arithmetic coprocessor that generalises the fixed
//  8-bit x/y datapath to a parametrised, handshaked unit with an integral

---
 rtl/gcd_div_coproc.sv | 167 ++++++++++++++++
 tb/tb_gcd_div_coproc.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_div_coproc.sv
// gcd_div_coproc: iterative subtract-based coprocessor.
// op=0 computes GCD by Euclid's subtraction, op=1 computes the unsigned
// quotient and remainder by repeated subtraction. Each side uses a
// valid/ready handshake. Only one operation is in flight at a time.
module gcd_div_coproc #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = WIDTH + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_a,
    output logic [WIDTH-1:0] result_b,
    output logic             div_err,
    output logic [CNT_W-1:0] iters
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_GCD = 1'b0;

    state_t           r_state;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_q;
    logic             r_op;
    logic [CNT_W-1:0] r_iters;
    logic [WIDTH-1:0] r_result_a;
    logic [WIDTH-1:0] r_result_b;
    logic             r_div_err;
    logic             r_in_ready;
    logic             r_out_valid;

    // Datapath comparisons and differences shared by both modes.
    logic             w_x_zero;
    logic             w_y_zero;
    logic             w_x_eq_y;
    logic             w_x_gt_y;
    logic             w_x_ge_y;
    logic [WIDTH-1:0] w_x_minus_y;
    logic [WIDTH-1:0] w_y_minus_x;
    logic [WIDTH-1:0] w_q_inc;
    logic [CNT_W-1:0] w_iters_inc;

    // Compare/subtract network. The differences are only consumed in the
    // branch whose compare guarantees they cannot underflow.
    always_comb begin
        w_x_zero    = (r_x == '0);
        w_y_zero    = (r_y == '0);
        w_x_eq_y    = (r_x == r_y);
        w_x_gt_y    = (r_x > r_y);
        w_x_ge_y    = (r_x >= r_y);
        w_x_minus_y = r_x - r_y;
        w_y_minus_x = r_y - r_x;
        w_q_inc     = r_q + WIDTH'(1);
        w_iters_inc = r_iters + CNT_W'(1);
    end

    // Controller and datapath registers: IDLE -> RUN -> DONE -> IDLE, with
    // all handshake outputs registered so nothing combinational reaches them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_q         <= '0;
            r_op        <= OP_GCD;
            r_iters     <= '0;
            r_result_a  <= '0;
            r_result_b  <= '0;
            r_div_err   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // in_ready is high whenever we are idle.
                    if (in_valid) begin
                        r_x        <= a;
                        r_y        <= b;
                        r_q        <= '0;
                        r_iters    <= '0;
                        r_op       <= op;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    // The terminating cycle is counted as well.
                    r_iters <= w_iters_inc;
                    if (r_op == OP_GCD) begin
                        if (w_x_zero) begin
                            r_result_a  <= r_y;
                            r_result_b  <= '0;
                            r_div_err   <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else if (w_y_zero || w_x_eq_y) begin
                            r_result_a  <= r_x;
                            r_result_b  <= '0;
                            r_div_err   <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else if (w_x_gt_y) begin
                            r_x <= w_x_minus_y;
                        end else begin
                            r_y <= w_y_minus_x;
                        end
                    end else begin
                        if (w_y_zero) begin
                            // Divide by zero: saturated quotient, dividend
                            // returned untouched as the remainder.
                            r_result_a  <= {WIDTH{1'b1}};
                            r_result_b  <= r_x;
                            r_div_err   <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else if (w_x_ge_y) begin
                            r_x <= w_x_minus_y;
                            r_q <= w_q_inc;
                        end else begin
                            r_result_a  <= r_q;
                            r_result_b  <= r_x;
                            r_div_err   <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    // Results stay put until the consumer takes them.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result_a  = r_result_a;
    assign result_b  = r_result_b;
    assign div_err   = r_div_err;
    assign iters     = r_iters;

endmodule

// File: tb/tb_gcd_div_coproc.sv
// Testbench for gcd_div_coproc: directed table, backpressure and reset
// sequences on an 8-bit instance, plus a 16-bit instance for the
// worst-case divide and back-to-back traffic, all against a reference model.
module tb_gcd_div_coproc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic       v8, ir8, op8, ov8, ordy8, err8;
    logic [7:0] a8, b8, ra8, rb8;
    logic [8:0] it8;

    logic        v16, ir16, op16, ov16, ordy16, err16;
    logic [15:0] a16, b16, ra16, rb16;
    logic [16:0] it16;

    gcd_div_coproc #(.WIDTH(8)) u_d8 (
        .clk(clk), .reset(reset), .in_valid(v8), .in_ready(ir8), .op(op8),
        .a(a8), .b(b8), .out_valid(ov8), .out_ready(ordy8),
        .result_a(ra8), .result_b(rb8), .div_err(err8), .iters(it8)
    );

    gcd_div_coproc #(.WIDTH(16)) u_d16 (
        .clk(clk), .reset(reset), .in_valid(v16), .in_ready(ir16), .op(op16),
        .a(a16), .b(b16), .out_valid(ov16), .out_ready(ordy16),
        .result_a(ra16), .result_b(rb16), .div_err(err16), .iters(it16)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: GCD subtraction steps equal the sum of the quotients of
    // the modulo form of Euclid; DIV takes quotient+1 steps.
    function automatic void model(input int w, input bit op, input int a, input int b,
                                  output int ra, output int rb, output int err, output int it);
        int x, y, t;
        ra = 0; rb = 0; err = 0; it = 1;
        if (op == 1'b0) begin
            if (a == 0)      ra = b;
            else if (b == 0) ra = a;
            else begin
                x = a; y = b; it = 0;
                while (y != 0) begin
                    it += x / y;
                    t = x % y;
                    x = y;
                    y = t;
                end
                ra = x;
            end
        end else begin
            if (b == 0) begin
                ra = (1 << w) - 1; rb = a; err = 1; it = 1;
            end else begin
                ra = a / b; rb = a % b; it = a / b + 1;
            end
        end
    endfunction

    // One operation on the 8-bit unit; hold>0 keeps out_ready low for that
    // many DONE cycles while pulsing in_valid, which must be ignored.
    task automatic run8(input bit op, input int a, input int b, input int e_ra,
                        input int e_rb, input int e_err, input int e_it,
                        input int hold, input string tag);
        int lat;
        @(negedge clk);
        check({tag, ":in_ready_idle"}, ir8, 1);
        v8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
        @(posedge clk); #1;
        v8 = 1'b0; op8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
        ordy8 = (hold == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        check({tag, ":in_ready_busy"}, ir8, 0);
        lat = 1;
        while (!ov8 && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ":latency"}, lat, e_it + 1);
        check({tag, ":result_a"}, ra8, e_ra);
        check({tag, ":result_b"}, rb8, e_rb);
        check({tag, ":div_err"}, err8, e_err);
        check({tag, ":iters"}, it8, e_it);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            v8 = 1'b1; op8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
            @(posedge clk); #1;
            v8 = 1'b0;
            check({tag, ":hold_valid"}, ov8, 1);
            check({tag, ":hold_result"}, {ra8, rb8}, {e_ra[7:0], e_rb[7:0]});
            check({tag, ":hold_in_ready"}, ir8, 0);
        end
        @(negedge clk);
        ordy8 = 1'b1;
        @(posedge clk); #1;
        ordy8 = 1'b0;
        check({tag, ":valid_drop"}, ov8, 0);
        check({tag, ":ready_rise"}, ir8, 1);
        check({tag, ":result_kept"}, ra8, e_ra);
        check({tag, ":iters_kept"}, it8, e_it);
        $display("[TB] w8 %s op=%0d a=%0d b=%0d -> ra=%0d rb=%0d err=%0d iters=%0d lat=%0d",
                 tag, op, a, b, ra8, rb8, err8, it8, lat);
    endtask

    // One operation on the 16-bit unit; out_ready is tied high throughout.
    task automatic run16(input bit op, input int a, input int b, input string tag);
        int lat, e_ra, e_rb, e_err, e_it;
        model(16, op, a, b, e_ra, e_rb, e_err, e_it);
        lat = 0;
        while (!ir16 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ":in_ready_idle"}, ir16, 1);
        v16 = 1'b1; op16 = op; a16 = a[15:0]; b16 = b[15:0];
        @(posedge clk); #1;
        v16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        lat = 1;
        while (!ov16 && lat < 70000) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ":latency"}, lat, e_it + 1);
        check({tag, ":result_a"}, ra16, e_ra);
        check({tag, ":result_b"}, rb16, e_rb);
        check({tag, ":div_err"}, err16, e_err);
        check({tag, ":iters"}, it16, e_it);
        $display("[TB] w16 %s op=%0d a=%0d b=%0d -> ra=%0d rb=%0d err=%0d iters=%0d lat=%0d",
                 tag, op, a, b, ra16, rb16, err16, it16, lat);
        @(posedge clk); #1;
        check({tag, ":valid_drop"}, ov16, 0);
    endtask

    typedef struct {
        bit    op;
        int    a;
        int    b;
        int    ra;
        int    rb;
        int    err;
        int    it;
        string tag;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b0, 12,  8,   4, 0, 0,   3, "gcd12_8"};
        vecs[1] = '{1'b1, 17,  5,   3, 2, 0,   4, "div17_5"};
        vecs[2] = '{1'b1,  3,  7,   0, 3, 0,   1, "div3_7"};
        vecs[3] = '{1'b1,  9,  0, 255, 9, 1,   1, "div9_0"};
        vecs[4] = '{1'b0,  0,  0,   0, 0, 0,   1, "gcd0_0"};
        vecs[5] = '{1'b0,  6,  0,   6, 0, 0,   1, "gcd6_0"};
        vecs[6] = '{1'b0,  0,  9,   9, 0, 0,   1, "gcd0_9"};
        vecs[7] = '{1'b0, 21, 14,   7, 0, 0,   3, "gcd21_14"};
        vecs[8] = '{1'b1, 255, 1, 255, 0, 0, 256, "div255_1"};

        reset = 1'b1;
        v8 = 1'b0; op8 = 1'b0; a8 = '0; b8 = '0; ordy8 = 1'b0;
        v16 = 1'b0; op16 = 1'b0; a16 = '0; b16 = '0; ordy16 = 1'b1;

        repeat (2) @(negedge clk);
        check("reset:in_ready", ir8, 1);
        check("reset:out_valid", ov8, 0);
        check("reset:results", {ra8, rb8}, 0);
        check("reset:div_err", err8, 0);
        check("reset:iters", it8, 0);
        check("reset:in_ready16", ir16, 1);
        reset = 1'b0;

        foreach (vecs[i])
            run8(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ra, vecs[i].rb,
                 vecs[i].err, vecs[i].it, 0, vecs[i].tag);

        // Backpressure: five DONE cycles with out_ready low and in_valid pulses.
        run8(1'b0, 12, 8, 4, 0, 0, 3, 5, "backpressure");

        // Asynchronous reset in the middle of a long divide.
        @(negedge clk);
        v8 = 1'b1; op8 = 1'b1; a8 = 8'd200; b8 = 8'd1;
        @(posedge clk); #1;
        v8 = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("midrun:busy", ir8, 0);
        reset = 1'b1;
        #1;
        check("midrun_reset:in_ready", ir8, 1);
        check("midrun_reset:out_valid", ov8, 0);
        check("midrun_reset:results", {ra8, rb8}, 0);
        check("midrun_reset:div_err", err8, 0);
        check("midrun_reset:iters", it8, 0);
        $display("[TB] w8 reset mid-run -> in_ready=%0d out_valid=%0d iters=%0d", ir8, ov8, it8);
        @(negedge clk);
        reset = 1'b0;
        run8(1'b0, 21, 14, 7, 0, 0, 3, 0, "after_reset");

        // Randomized traffic against the reference model.
        for (int n = 0; n < 60; n++) begin
            bit op;
            int a, b, ra, rb, err, it;
            op = 1'($urandom_range(0, 1));
            a  = $urandom_range(0, 255);
            b  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 255);
            model(8, op, a, b, ra, rb, err, it);
            run8(op, a, b, ra, rb, err, it, $urandom_range(0, 2), "rand");
        end

        // Wide instance: worst-case divide, then back-to-back operations.
        run16(1'b1, 65535, 1, "div65535_1");
        check("w16:worst_iters", it16, 65536);
        run16(1'b0, 0, 0, "gcd0_0");
        run16(1'b1, 1234, 0, "div_by_zero");
        for (int n = 0; n < 6; n++) begin
            if (n % 2 == 0)
                run16(1'b1, $urandom_range(0, 65535), $urandom_range(256, 65535), "rand_div");
            else
                run16(1'b0, $urandom_range(1000, 3000), $urandom_range(1000, 3000), "rand_gcd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
